// File: rtl/fork_join_pkg.sv
// ---------------------------------------------------------------------------
// fork_join_pkg
// Shared types and constants for the fork/join controller:
//   join_mode_e  - join semantics latched at fork accept
//   state_e      - controller FSM states
//   MODE_*       - raw encodings of the mode_i input
//   decode_mode  - maps the raw 2-bit mode onto join_mode_e (reserved -> ALL)
// ---------------------------------------------------------------------------
package fork_join_pkg;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'b00,
    JOIN_ANY  = 2'b01,
    JOIN_NONE = 2'b10
  } join_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_ANY  = 2'b01;
  localparam logic [1:0] MODE_NONE = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // The reserved encoding behaves exactly like ALL.
  function automatic join_mode_e decode_mode(input logic [1:0] m);
    join_mode_e r;
    case (m)
      MODE_ANY:            r = JOIN_ANY;
      MODE_NONE:           r = JOIN_NONE;
      MODE_ALL, MODE_RSVD: r = JOIN_ALL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fj_channel.sv
// ---------------------------------------------------------------------------
// fj_channel
// One timed fork channel: a countdown counter with busy flag and a
// registered one-cycle completion pulse.
//   clk, rst : clock, asynchronous active-high reset
//   load     : fork accepted with this channel enabled (loads delay)
//   kill     : abort the channel without emitting a completion pulse
//   delay    : programmed delay D in cycles
//   busy     : high for D cycles after the load edge
//   done     : one-cycle pulse in the cycle after the last busy cycle
//              (immediately after the load edge when D = 0)
// ---------------------------------------------------------------------------
module fj_channel #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          kill,
  input  logic [DW-1:0] delay,
  output logic          busy,
  output logic          done
);

  logic [DW-1:0] cnt;

  // cnt holds the number of busy cycles still to come, including the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        if (delay == '0) begin
          done <= 1'b1;
        end else begin
          busy <= 1'b1;
          cnt  <= delay;
        end
      end else if (kill) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (busy) begin
        if (cnt == DW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// ---------------------------------------------------------------------------
// fork_join_ctrl
// Fork/join controller: one accepted start launches up to N timed channels;
// join_done_o pulses according to the latched join mode (ALL / ANY / NONE).
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start_i        fork request, accepted when start_i & start_ready_o
//   start_ready_o  high only in IDLE
//   mode_i         00 ALL, 01 ANY, 10 NONE, 11 treated as ALL (sampled at accept)
//   en_i           channel enable mask (sampled at accept)
//   delay_i        per-channel delay, channel k at [k*DW +: DW] (sampled at accept)
//   kill_i         (only with FORK_JOIN_CTRL_DISABLE_FORK_EN) abort running fork
//   ch_busy_o      channel counting
//   ch_done_o      one-cycle completion pulse per channel
//   join_done_o    one-cycle pulse when the join condition is met
//   first_id_o     lowest channel index pulsing in the first completion cycle
//   active_cnt_o   popcount of ch_busy_o
//   time_o         cycles since last accept, saturating at all-ones
//
// Build option: define FORK_JOIN_CTRL_DISABLE_FORK_EN to add kill_i.
// ---------------------------------------------------------------------------
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 5,
  parameter int TW = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  output logic                           start_ready_o,
  input  logic [1:0]                     mode_i,
  input  logic [N-1:0]                   en_i,
  input  logic [N*DW-1:0]                delay_i,
`ifdef FORK_JOIN_CTRL_DISABLE_FORK_EN
  input  logic                           kill_i,
`endif
  output logic [N-1:0]                   ch_busy_o,
  output logic [N-1:0]                   ch_done_o,
  output logic                           join_done_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] first_id_o,
  output logic [$clog2(N+1)-1:0]         active_cnt_o,
  output logic [TW-1:0]                  time_o
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(N+1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Scan downward so the lowest set index is the one left standing.
  function automatic logic [IDW-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  logic [1:0]     state;
  join_mode_e     mode_q;
  logic [N-1:0]   mask_q;
  logic [N-1:0]   seen_q;
  logic           got_first_q;
  logic [IDW-1:0] id_q;
  logic [TW-1:0]  time_q;

  logic accept;
  logic kill_w;
  logic busy_any;
  logic all_met;
  logic any_met;
  logic join_met;

  assign start_ready_o = (state == S_IDLE);
  assign accept        = start_i & start_ready_o;

`ifdef FORK_JOIN_CTRL_DISABLE_FORK_EN
  assign kill_w = kill_i & (state != S_IDLE);
`else
  assign kill_w = 1'b0;
`endif

  // Channel array
  for (genvar k = 0; k < N; k++) begin : g_ch
    fj_channel #(.DW(DW)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .load  (accept & en_i[k]),
      .kill  (kill_w),
      .delay (delay_i[k*DW +: DW]),
      .busy  (ch_busy_o[k]),
      .done  (ch_done_o[k])
    );
  end

  // Join reduction: an empty mask satisfies every mode in the first run cycle.
  assign busy_any = |ch_busy_o;
  assign all_met  = (((seen_q | ch_done_o) & mask_q) == mask_q);
  assign any_met  = (|ch_done_o) | (mask_q == '0);

  always_comb begin
    join_met = all_met;
    case (mode_q)
      JOIN_ANY:  join_met = any_met;
      JOIN_NONE: join_met = 1'b1;
      default:   join_met = all_met;
    endcase
  end

  assign join_done_o  = (state == S_RUN) & join_met;
  assign active_cnt_o = popcount(ch_busy_o);
  assign time_o       = time_q;

  // The first completion cycle shows its winner combinationally; it is then held.
  assign first_id_o = (!got_first_q && (|ch_done_o)) ? lowest_idx(ch_done_o) : id_q;

  // FSM and per-fork bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= JOIN_ALL;
      mask_q      <= '0;
      seen_q      <= '0;
      got_first_q <= 1'b0;
      id_q        <= '0;
      time_q      <= '0;
    end else begin
      time_q <= accept ? TW'(1) : sat_inc(time_q);

      if (accept) begin
        mode_q      <= decode_mode(mode_i);
        mask_q      <= en_i;
        seen_q      <= '0;
        got_first_q <= 1'b0;
        id_q        <= '0;
      end else begin
        seen_q <= seen_q | ch_done_o;
        if (!got_first_q && (|ch_done_o)) begin
          got_first_q <= 1'b1;
          id_q        <= lowest_idx(ch_done_o);
        end
      end

      case (state)
        S_IDLE: begin
          if (accept) state <= S_RUN;
        end
        S_RUN: begin
          if (kill_w) state <= S_IDLE;
          else if (join_met) state <= busy_any ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: begin
          if (kill_w || !busy_any) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
